// File: rtl/mul_core_pkg.sv
// Shared definitions for the multiplier core, its result writer and the SRAM wrapper.
package mul_core_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_RESULT_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH   = 7;
    localparam int DEF_MEM_DEPTH    = 128;

endpackage

// File: rtl/mul_result_addr_cnt.sv
// Batch address counter: cleared and loaded with the batch length on start,
// advanced once per captured result, flags the capture that completes the batch.
module mul_result_addr_cnt
    import mul_core_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH:0]   i_num_cnt,
    input  logic                  i_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH:0] r_cnt;
    logic [ADDR_WIDTH:0] r_num;
    logic [ADDR_WIDTH:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + (ADDR_WIDTH+1)'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_num <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_num <= i_num_cnt;
        end else if (i_en) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // The counter is one bit wider than the address so a full-depth batch can terminate.
    assign o_addr = r_cnt[ADDR_WIDTH-1:0];
    assign o_last = i_en && (w_cnt_nxt == r_num);

endmodule

// File: rtl/mul_result_writer.sv
// Writes the multiplier result stream into the result SRAM, one batch per start pulse.
// Optional running sum of written results: define MUL_RESULT_SUM_EN.
module mul_result_writer
    import mul_core_pkg::*;
#(
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH    = DEF_MEM_DEPTH
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               i_run,
    input  logic [ADDR_WIDTH:0]                i_num_cnt,
    input  logic                               i_valid,
    input  logic [RESULT_WIDTH-1:0]            i_result,
    output logic [ADDR_WIDTH-1:0]              o_addr,
    output logic                               o_ce,
    output logic                               o_we,
    output logic [RESULT_WIDTH-1:0]            o_d,
    output logic                               o_idle,
    output logic                               o_running,
    output logic                               o_done,
`ifdef MUL_RESULT_SUM_EN
    output logic [RESULT_WIDTH+ADDR_WIDTH:0]   o_sum,
`endif
    output logic                               o_err
);

    localparam logic [ADDR_WIDTH:0] L_DEPTH = MEM_DEPTH[ADDR_WIDTH:0];

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_start;
    logic                    w_capture;
    logic                    w_drop;
    logic                    w_last;
    logic [ADDR_WIDTH:0]     w_num_clamped;
    logic [ADDR_WIDTH-1:0]   w_cnt_addr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [RESULT_WIDTH-1:0] r_d;
    logic                    r_we;
    logic                    r_err;

    assign w_start       = (r_state == S_IDLE) && i_run;
    assign w_capture     = (r_state == S_RUN) && i_valid;
    assign w_drop        = i_valid && (r_state != S_RUN);
    assign w_num_clamped = (i_num_cnt > L_DEPTH) ? L_DEPTH : i_num_cnt;

    mul_result_addr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_start),
        .i_num_cnt (w_num_clamped),
        .i_en      (w_capture),
        .o_addr    (w_cnt_addr),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_run) w_state_nxt = (w_num_clamped == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_last) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_d    <= '0;
            r_err  <= 1'b0;
        end else begin
            r_we <= w_capture;
            if (w_capture) begin
                r_addr <= w_cnt_addr;
                r_d    <= i_result;
            end
            // A drop in the same cycle as a start still reports the lost result.
            if (w_drop)       r_err <= 1'b1;
            else if (w_start) r_err <= 1'b0;
        end
    end

`ifdef MUL_RESULT_SUM_EN
    logic [RESULT_WIDTH+ADDR_WIDTH:0] r_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_sum <= '0;
        else if (w_start)   r_sum <= '0;
        else if (w_capture) r_sum <= r_sum + (RESULT_WIDTH+ADDR_WIDTH+1)'(i_result);
    end

    assign o_sum = r_sum;
`endif

    assign o_addr    = r_addr;
    assign o_d       = r_d;
    assign o_ce      = r_we;
    assign o_we      = r_we;
    assign o_err     = r_err;
    assign o_idle    = (r_state == S_IDLE);
    assign o_running = (r_state == S_RUN);
    assign o_done    = (r_state == S_DONE);

endmodule

// File: doc/mul_result_writer.md
# mul_result_writer

Downstream stage of the multiplier core. It consumes the core's registered valid/result stream and writes each result into a single-port result SRAM at consecutive addresses. A start/count/done handshake with the host controller bounds each batch. Results that arrive outside an active batch are dropped and flagged.

## Interface
Parameters:
- RESULT_WIDTH, 16, width of one multiplier result (2× operand width)
- ADDR_WIDTH, 7, result SRAM address width
- MEM_DEPTH, 128, result SRAM depth (≤ 2^ADDR_WIDTH)

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- i_run  input  1  start-batch pulse, accepted only in S_IDLE
- i_num_cnt  input  ADDR_WIDTH+1  results in batch, 0..MEM_DEPTH, sampled with accepted i_run
- i_valid  input  1  result valid from multiplier
- i_result  input  RESULT_WIDTH  multiplier result
- o_addr  output  ADDR_WIDTH  SRAM address
- o_ce  output  1  SRAM chip enable
- o_we  output  1  SRAM write enable
- o_d  output  RESULT_WIDTH  SRAM write data
- o_idle  output  1  FSM in S_IDLE
- o_running  output  1  FSM in S_RUN
- o_done  output  1  one-cycle batch-complete pulse
- o_err  output  1  sticky drop flag

## Operation
- FSM states: S_IDLE, S_RUN, S_DONE (2-bit, registered).
  - S_IDLE → S_RUN on i_run with i_num_cnt ≠ 0.
  - S_IDLE → S_DONE on i_run with i_num_cnt = 0.
  - S_RUN → S_DONE when the valid that makes the write count equal num_cnt is captured.
  - S_DONE → S_IDLE unconditionally after one cycle.
- Accepted i_run:
  - latches num_cnt;
  - clears the write counter;
  - clears o_err.
- i_run in S_RUN or S_DONE is ignored; it has no effect on num_cnt or the counter.
- In S_RUN, each i_valid:
  - registers {addr = counter, data = i_result} onto the write port;
  - increments the counter.
  - Every accepted valid is written; there is no backpressure.
- i_valid in S_IDLE or S_DONE: the result is discarded, no write occurs, and o_err is set. o_err holds until the next accepted i_run or reset.
- i_num_cnt > MEM_DEPTH is clamped to MEM_DEPTH at sampling time.
- The address never wraps within a batch. The counter restarts at 0 for each batch.
- o_idle = (state == S_IDLE); o_running = (state == S_RUN); o_done = (state == S_DONE).

## Timing
- Reset values:
  - state = S_IDLE
  - o_addr = 0, o_d = 0
  - o_ce = o_we = 0
  - o_done = 0, o_err = 0, o_running = 0
  - o_idle = 1
- i_run accepted at edge T: o_running is high from T+1.
- i_valid sampled at edge t in S_RUN: o_ce = o_we = 1 with that address and data during cycle t+1, for exactly one cycle per valid. Write latency is 1 cycle.
- Back-to-back valids give back-to-back writes at full rate.
- Last valid at edge t: S_DONE (o_done = 1) and the last write are both in cycle t+1; S_IDLE at t+2.
- An i_run arriving in the same cycle as o_done is ignored. The earliest new start is sampled in the next cycle.
- Reset asserted mid-batch: all state and outputs return to reset values immediately. A pending write strobe is cancelled. The SRAM contents are not touched.

## Configuration
- Macro MUL_RESULT_SUM_EN.
- Defined:
  - adds output o_sum, RESULT_WIDTH+ADDR_WIDTH+1 bits, unsigned;
  - o_sum accumulates every written result;
  - o_sum is cleared on accepted i_run and on reset;
  - o_sum updates in the same cycle as the corresponding write strobe;
  - o_sum is stable from o_done until the next start.
- Undefined: the o_sum port and its accumulator are absent. All other behaviour is identical.

## Structure
- Shared package mul_core_pkg holds:
  - state encodings S_IDLE = 0, S_RUN = 1, S_DONE = 2;
  - default RESULT_WIDTH, ADDR_WIDTH, MEM_DEPTH constants, shared with the multiplier core and the SRAM wrapper.
- One sub-module is natural: mul_result_addr_cnt. It is a clearable, enabled address counter with terminal-count compare against the latched num_cnt. The FSM and write-port registers stay in the top module.

## Test plan
- Reset, then idle for 5 cycles → o_idle = 1, o_ce = o_we = o_done = o_err = 0, o_addr = 0.
- i_run with num_cnt = 4, then 4 consecutive valids with results 0x0006, 0x0015, 0xFE01, 0x0000 → writes to addr 0..3 in consecutive cycles; o_done pulses with the addr-3 write; with MUL_RESULT_SUM_EN, o_sum = 0xFE1C.
- num_cnt = 3, valids separated by 2 idle cycles → exactly 3 isolated write strobes at addr 0, 1, 2; the FSM stays in S_RUN between them.
- Valid while idle, result 0x1234 → no write, o_err = 1; the next i_run clears o_err.
- i_run with num_cnt = 0 → o_done pulses at T+1 with no write strobe; i_num_cnt = 200 → 128 writes, last at addr 127.
- Reset asserted after 2 of 5 writes → outputs at reset values the same cycle; a new i_run with num_cnt = 1 writes at addr 0.
